// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if
// Bus between the memory-access stage and a synchronous single-port data RAM.
//
// Signals:
//   mem_addr  word address presented to the RAM
//   mem_data  write data
//   mem_wren  write enable (one cycle per store)
//   mem_q     read data, valid READ_LATENCY edges after the address is captured
//
// Modports:
//   master  the memory stage (drives address/data/wren, receives q)
//   slave   the RAM (receives address/data/wren, drives q)
// ---------------------------------------------------------------------------
interface mem_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport master (
        output mem_addr,
        output mem_data,
        output mem_wren,
        input  mem_q
    );

    modport slave (
        input  mem_addr,
        input  mem_data,
        input  mem_wren,
        output mem_q
    );
endinterface

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Memory-access stage between the M control bundle and the mwpipe register.
// Issues loads/stores to a synchronous single-port RAM, stalls upstream while
// load data is in flight, and presents a registered bundle to the mwpipe.
//
// Parameters:
//   DATA_W        datapath / RAM word width
//   ADDR_W        RAM word-address width (word address = ALUrslt_M[ADDR_W+1:2])
//   REG_W         destination register index width
//   READ_LATENCY  edges from RAM address capture to valid q (legal 1..4)
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   valid_M, flush_M    M bundle valid / synchronous kill
//   pcload_M, regw_M    control passthrough
//   regmem_M, memw_M    load / store request
//   regScr_M            destination register index
//   ALUrslt_M, wdata_M  ALU result (byte address) / store data
//   stall_o             combinational hold for upstream stages
//   ram                 RAM bus (mem_stage_if.master)
//   valid_o .. rdata_o  registered bundle feeding the mwpipe _M inputs
//   misalign_o          registered one-cycle trap flag (MISALIGN_TRAP_EN only)
//
// Optional feature macro: MISALIGN_TRAP_EN
//   When defined, a load or store with ALUrslt_M[1:0] != 0 makes no RAM access,
//   does not stall, and is registered as a valid bubble with misalign_o pulsed.
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 10,
    parameter int REG_W        = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              valid_M,
    input  logic              flush_M,
    input  logic              pcload_M,
    input  logic              regw_M,
    input  logic              regmem_M,
    input  logic              memw_M,
    input  logic [REG_W-1:0]  regScr_M,
    input  logic [DATA_W-1:0] ALUrslt_M,
    input  logic [DATA_W-1:0] wdata_M,

    output logic              stall_o,
    mem_stage_if.master       ram,

    output logic              valid_o,
    output logic              pcload_o,
    output logic              regw_o,
    output logic              regmem_o,
    output logic [REG_W-1:0]  regScr_o,
    output logic [DATA_W-1:0] ALUrslt_o,
    output logic [DATA_W-1:0] rdata_o
`ifdef MISALIGN_TRAP_EN
    ,
    output logic              misalign_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter holds at most READ_LATENCY-1 = 3.
    localparam int CNT_W = 3;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    logic               valid_q, valid_d;
    logic               pcload_q, pcload_d;
    logic               regw_q, regw_d;
    logic               regmem_q, regmem_d;
    logic [REG_W-1:0]   regScr_q, regScr_d;
    logic [DATA_W-1:0]  alu_q, alu_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               misalign_q, misalign_d;

    logic [ADDR_W-1:0]  word_addr;
    logic               accept;
    logic               misaligned;
    logic               is_load;
    logic               is_store;
    logic               stall;
    logic               wren;
    logic [ADDR_W-1:0]  mem_addr;

    // Upper address bits beyond the RAM depth are dropped, so addresses wrap.
    assign word_addr = ALUrslt_M[ADDR_W+1:2];
    assign accept    = valid_M & ~flush_M;

`ifdef MISALIGN_TRAP_EN
    assign misaligned = (regmem_M | memw_M) & (ALUrslt_M[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // A load wins over a simultaneous store request.
    assign is_load  = accept & regmem_M & ~misaligned;
    assign is_store = accept & memw_M & ~regmem_M & ~misaligned;

    always_comb begin
        // NOTE: every variable gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        valid_d    = 1'b0;
        pcload_d   = pcload_q;
        regw_d     = regw_q;
        regmem_d   = regmem_q;
        regScr_d   = regScr_q;
        alu_d      = alu_q;
        rdata_d    = rdata_q;
        misalign_d = 1'b0;
        stall      = 1'b0;
        wren       = 1'b0;
        mem_addr   = addr_q;

        unique case (state_q)
            S_IDLE: begin
                mem_addr = word_addr;
                if (!accept) begin
                    pcload_d = 1'b0;
                    regw_d   = 1'b0;
                    regmem_d = 1'b0;
                    regScr_d = '0;
                    alu_d    = '0;
                    rdata_d  = '0;
                end else if (is_load) begin
                    // Issue the read now; the bundle stays a bubble until DONE.
                    stall  = 1'b1;
                    addr_d = word_addr;
                    if (READ_LATENCY == 1) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(READ_LATENCY - 1);
                    end
                end else begin
                    // ALU op, store, or (with the trap enabled) misaligned access.
                    wren       = is_store;
                    valid_d    = 1'b1;
                    pcload_d   = pcload_M;
                    regw_d     = regw_M & ~misaligned;
                    regmem_d   = regmem_M & ~misaligned;
                    regScr_d   = regScr_M;
                    alu_d      = ALUrslt_M;
                    rdata_d    = '0;
                    misalign_d = misaligned;
                end
            end

            S_WAIT: begin
                if (flush_M) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    stall = 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end

            S_DONE: begin
                // Upstream is still holding the load, so its fields are current.
                state_d = S_IDLE;
                if (!flush_M) begin
                    valid_d  = 1'b1;
                    pcload_d = pcload_M;
                    regw_d   = regw_M;
                    regmem_d = regmem_M;
                    regScr_d = regScr_M;
                    alu_d    = ALUrslt_M;
                    rdata_d  = ram.mem_q;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Combinational outputs are forced quiet while reset is asserted.
    assign stall_o      = stall & ~rst;
    assign ram.mem_wren = wren & ~rst;
    assign ram.mem_addr = mem_addr;
    assign ram.mem_data = wdata_M;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its _d value from before the edge, independent of order.
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            pcload_q   <= 1'b0;
            regw_q     <= 1'b0;
            regmem_q   <= 1'b0;
            regScr_q   <= '0;
            alu_q      <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            pcload_q   <= pcload_d;
            regw_q     <= regw_d;
            regmem_q   <= regmem_d;
            regScr_q   <= regScr_d;
            alu_q      <= alu_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
        end
    end

    assign valid_o   = valid_q;
    assign pcload_o  = pcload_q;
    assign regw_o    = regw_q;
    assign regmem_o  = regmem_q;
    assign regScr_o  = regScr_q;
    assign ALUrslt_o = alu_q;
    assign rdata_o   = rdata_q;

`ifdef MISALIGN_TRAP_EN
    assign misalign_o = misalign_q;
`else
    // Without the trap the flag is always zero; keep it referenced.
    logic unused_misalign;
    assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage: a vector table for single-cycle ops,
// hand-written load/flush/reset sequences, and a randomized instruction stream
// checked against a transaction-level model (memory array + latency rule).
// Build with +define+MISALIGN_TRAP_EN to exercise the trap.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_stage;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int REG_W  = 4;
    localparam int RL     = 2;

    logic clk = 1'b0;
    logic rst;
    logic valid_M, flush_M, pcload_M, regw_M, regmem_M, memw_M;
    logic [REG_W-1:0]  regScr_M;
    logic [DATA_W-1:0] ALUrslt_M, wdata_M;
    logic stall_o, valid_o, pcload_o, regw_o, regmem_o;
    logic [REG_W-1:0]  regScr_o;
    logic [DATA_W-1:0] ALUrslt_o, rdata_o;
`ifdef MISALIGN_TRAP_EN
    logic misalign_o;
`endif

    mem_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ram_if();

    mem_stage #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .rst(rst),
        .valid_M(valid_M), .flush_M(flush_M), .pcload_M(pcload_M),
        .regw_M(regw_M), .regmem_M(regmem_M), .memw_M(memw_M),
        .regScr_M(regScr_M), .ALUrslt_M(ALUrslt_M), .wdata_M(wdata_M),
        .stall_o(stall_o), .ram(ram_if),
        .valid_o(valid_o), .pcload_o(pcload_o), .regw_o(regw_o),
        .regmem_o(regmem_o), .regScr_o(regScr_o), .ALUrslt_o(ALUrslt_o),
        .rdata_o(rdata_o)
`ifdef MISALIGN_TRAP_EN
        , .misalign_o(misalign_o)
`endif
    );

    always #5 clk = ~clk;

    // RAM device: address captured on an edge, data appears after RL edges.
    logic [DATA_W-1:0] ram [1<<ADDR_W];
    logic [DATA_W-1:0] rd_pipe [RL];
    always @(posedge clk) begin
        if (ram_if.mem_wren) ram[ram_if.mem_addr] <= ram_if.mem_data;
        rd_pipe[0] <= ram[ram_if.mem_addr];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_if.mem_q = rd_pipe[RL-1];

    int wren_cnt = 0;
    always @(posedge clk) if (ram_if.mem_wren) wren_cnt++;

    // Reference memory: only words the bench has stored are known.
    logic [DATA_W-1:0] model_mem [int];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, f, pc, rw, rm, mw, input logic [3:0] rs,
                         input logic [31:0] alu, wd);
        valid_M = v; flush_M = f; pcload_M = pc; regw_M = rw; regmem_M = rm;
        memw_M = mw; regScr_M = rs; ALUrslt_M = alu; wdata_M = wd;
        #1;
    endtask

    task automatic expect_bundle(input string tag, input logic v, pc, rw, rm,
                                 input logic [3:0] rs, input logic [31:0] alu, rd,
                                 input bit chk_rd, input logic mis);
        check({tag, ".valid"},  32'(valid_o),  32'(v));
        check({tag, ".pcload"}, 32'(pcload_o), 32'(pc));
        check({tag, ".regw"},   32'(regw_o),   32'(rw));
        check({tag, ".regmem"}, 32'(regmem_o), 32'(rm));
        check({tag, ".regScr"}, 32'(regScr_o), 32'(rs));
        check({tag, ".alu"},    ALUrslt_o,     alu);
        if (chk_rd) check({tag, ".rdata"}, rdata_o, rd);
`ifdef MISALIGN_TRAP_EN
        check({tag, ".misalign"}, 32'(misalign_o), 32'(mis));
`else
        if (mis) $display("note: misalign expectation ignored in %s", tag);
`endif
    endtask

    // Any non-load instruction: one cycle, no stall.
    task automatic exec_nonload(input string tag, input logic v, f, pc, rw, mw,
                                input logic [3:0] rs, input logic [31:0] alu, wd);
        logic acc, st;
        logic [ADDR_W-1:0] w;
        acc = v & ~f;
        st  = acc & mw;
        w   = alu[ADDR_W+1:2];
        drive(v, f, pc, rw, 1'b0, mw, rs, alu, wd);
        check({tag, ".stall"}, 32'(stall_o), 32'd0);
        check({tag, ".wren"}, 32'(ram_if.mem_wren), 32'(st));
        if (st) begin
            check({tag, ".addr"}, 32'(ram_if.mem_addr), 32'(w));
            check({tag, ".data"}, ram_if.mem_data, wd);
        end
        tick();
        if (acc) expect_bundle(tag, 1'b1, pc, rw, 1'b0, rs, alu, 32'd0, 1'b1, 1'b0);
        else     expect_bundle(tag, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        if (st) model_mem[int'(w)] = wd;
    endtask

    // Load: stall for RL cycles, result at the following edge. flush_at in
    // 1..RL-1 aborts during the wait, flush_at == RL aborts in the result cycle.
    task automatic exec_load(input string tag, input logic pc, rw, mw,
                             input logic [3:0] rs, input logic [31:0] alu, input int flush_at);
        logic [ADDR_W-1:0] w;
        logic [31:0] wd;
        w  = alu[ADDR_W+1:2];
        wd = $urandom();
        drive(1'b1, 1'b0, pc, rw, 1'b1, mw, rs, alu, wd);
        for (int k = 0; k <= RL; k++) begin
            if (k == flush_at) begin
                flush_M = 1'b1;
                #1;
                check({tag, ".flush_stall"}, 32'(stall_o), 32'd0);
                check({tag, ".flush_wren"}, 32'(ram_if.mem_wren), 32'd0);
                tick();
                check({tag, ".flush_valid"}, 32'(valid_o), 32'd0);
                return;
            end
            if (k < RL) begin
                check({tag, ".stall"}, 32'(stall_o), 32'd1);
                check({tag, ".wren"}, 32'(ram_if.mem_wren), 32'd0);
                check({tag, ".addr"}, 32'(ram_if.mem_addr), 32'(w));
                tick();
                check({tag, ".bubble"}, 32'(valid_o), 32'd0);
            end else begin
                check({tag, ".done_stall"}, 32'(stall_o), 32'd0);
                check({tag, ".done_wren"}, 32'(ram_if.mem_wren), 32'd0);
                tick();
                expect_bundle(tag, 1'b1, pc, rw, 1'b1, rs, alu,
                              model_mem.exists(int'(w)) ? model_mem[int'(w)] : 32'd0,
                              model_mem.exists(int'(w)), 1'b0);
            end
        end
    endtask

    typedef struct {
        logic v, f, pc, rw, mw;
        logic [3:0]  rs;
        logic [31:0] alu, wd;
        logic exp_valid, exp_pc, exp_rw, exp_wren, exp_mis;
        logic [3:0]  exp_rs;
        logic [31:0] exp_alu;
        logic [9:0]  exp_addr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // ALU op
        vecs[0] = '{1,0,0,1,0, 4'd3, 32'h0000FFFF, 32'h0, 1,0,1,0,0, 4'd3, 32'h0000FFFF, 10'd0};
        // Store to 0x10 -> word 4
        vecs[1] = '{1,0,0,0,1, 4'd0, 32'h00000010, 32'hDEADBEEF, 1,0,0,1,0, 4'd0, 32'h10, 10'd4};
        // valid_M=0 with junk fields -> all zero
        vecs[2] = '{0,0,1,1,0, 4'd7, 32'h00001234, 32'h0, 0,0,0,0,0, 4'd0, 32'h0, 10'd0};
        // flushed store -> bubble, no write
        vecs[3] = '{1,1,1,1,1, 4'd9, 32'h00000020, 32'h11111111, 0,0,0,0,0, 4'd0, 32'h0, 10'd0};
        // store with high bits set wraps to word 2
        vecs[4] = '{1,0,1,0,1, 4'd1, 32'hFFFFF008, 32'hA5A50001, 1,1,0,1,0, 4'd1, 32'hFFFFF008, 10'd2};
        // store with low bits set
`ifdef MISALIGN_TRAP_EN
        vecs[5] = '{1,0,0,1,1, 4'd2, 32'h0000002B, 32'h0BADF00D, 1,0,0,0,1, 4'd2, 32'h2B, 10'd10};
`else
        vecs[5] = '{1,0,0,1,1, 4'd2, 32'h0000002B, 32'h0BADF00D, 1,0,1,1,0, 4'd2, 32'h2B, 10'd10};
`endif
        vecs[6] = '{1,0,1,1,0, 4'hF, 32'hFFFFFFFF, 32'h0, 1,1,1,0,0, 4'hF, 32'hFFFFFFFF, 10'd0};
        vecs[7] = '{1,0,1,0,0, 4'd8, 32'h80000000, 32'h0, 1,1,0,0,0, 4'd8, 32'h80000000, 10'd0};

        // ---------------- reset state ----------------
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 4'd0, 32'd0, 32'd0);
        tick();
        tick();
        check("reset.stall", 32'(stall_o), 32'd0);
        check("reset.wren", 32'(ram_if.mem_wren), 32'd0);
        expect_bundle("reset", 0, 0, 0, 0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- vector table ----------------
        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].v, vecs[i].f, vecs[i].pc, vecs[i].rw, 1'b0, vecs[i].mw,
                  vecs[i].rs, vecs[i].alu, vecs[i].wd);
            check({tag, ".stall"}, 32'(stall_o), 32'd0);
            check({tag, ".wren"}, 32'(ram_if.mem_wren), 32'(vecs[i].exp_wren));
            if (vecs[i].exp_wren) begin
                check({tag, ".addr"}, 32'(ram_if.mem_addr), 32'(vecs[i].exp_addr));
                check({tag, ".data"}, ram_if.mem_data, vecs[i].wd);
                model_mem[int'(vecs[i].exp_addr)] = vecs[i].wd;
            end
            tick();
            expect_bundle(tag, vecs[i].exp_valid, vecs[i].exp_pc, vecs[i].exp_rw, 1'b0,
                          vecs[i].exp_rs, vecs[i].exp_alu, 32'd0, 1'b1, vecs[i].exp_mis);
        end

        // ---------------- store pulse width ----------------
        begin
            int c0;
            c0 = wren_cnt;
            exec_nonload("st_pulse", 1, 0, 0, 0, 1, 4'd0, 32'h00000010, 32'hDEADBEEF);
            exec_nonload("st_idle", 0, 0, 0, 0, 0, 4'd0, 32'd0, 32'd0);
            check("st_pulse.count", 32'(wren_cnt - c0), 32'd1);
        end

        // ---------------- load after store, then back-to-back ALU op ----------------
        exec_load("ld10", 1'b0, 1'b1, 1'b0, 4'd4, 32'h00000010, -1);
        check("ld10.deadbeef", rdata_o, 32'hDEADBEEF);
        exec_nonload("b2b_alu", 1, 0, 0, 1, 0, 4'd5, 32'h00000077, 32'd0);

        // ---------------- flush during wait / during result cycle ----------------
        exec_load("ld_flush_wait", 1'b0, 1'b1, 1'b0, 4'd6, 32'h00000010, 1);
        exec_nonload("after_flush", 1, 0, 1, 1, 0, 4'd2, 32'h00000099, 32'd0);
        exec_load("ld_flush_done", 1'b1, 1'b1, 1'b0, 4'd7, 32'h00000010, RL);
        // load+store together acts as a load with no write
        exec_load("ld_and_st", 1'b0, 1'b1, 1'b1, 4'd1, 32'h00000008, -1);

`ifdef MISALIGN_TRAP_EN
        // ---------------- misaligned accesses ----------------
        drive(1, 0, 0, 1, 0, 1, 4'd6, 32'h00000012, 32'h5555AAAA);
        check("mis_st.wren", 32'(ram_if.mem_wren), 32'd0);
        check("mis_st.stall", 32'(stall_o), 32'd0);
        tick();
        expect_bundle("mis_st", 1, 0, 0, 0, 4'd6, 32'h12, 32'd0, 1'b1, 1'b1);
        exec_nonload("mis_clear", 1, 0, 0, 1, 0, 4'd1, 32'h00000004, 32'd0);
        drive(1, 0, 1, 1, 1, 0, 4'd3, 32'h00000021, 32'd0);
        check("mis_ld.stall", 32'(stall_o), 32'd0);
        tick();
        expect_bundle("mis_ld", 1, 1, 0, 0, 4'd3, 32'h21, 32'd0, 1'b1, 1'b1);
`endif

        // ---------------- reset in the middle of a load wait ----------------
        drive(1, 0, 1, 1, 1, 0, 4'd5, 32'h00000040, 32'd0);
        check("rst_ld.stall0", 32'(stall_o), 32'd1);
        tick();
        check("rst_ld.stall1", 32'(stall_o), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_ld.stall", 32'(stall_o), 32'd0);
        check("rst_ld.wren", 32'(ram_if.mem_wren), 32'd0);
        expect_bundle("rst_ld", 0, 0, 0, 0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_rel.wren", 32'(ram_if.mem_wren), 32'd0);
            check("rst_rel.stall", 32'(stall_o), 32'd0);
            check("rst_rel.valid", 32'(valid_o), 32'd0);
        end

        // ---------------- randomized stream vs. model ----------------
        for (int w = 0; w < 16; w++) begin
            logic [31:0] r;
            r = $urandom();
            exec_nonload("rnd_init", 1, 0, 0, 0, 1, 4'd0,
                         {r[31:12], 6'd0, 4'(w), 2'b00}, $urandom());
        end
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r, r2, addr;
            int kind;
            r    = $urandom();
            r2   = $urandom();
            kind = int'($urandom_range(0, 9));
            addr = {r[31:12], 6'd0, r2[3:0], 2'b00};
            case (kind)
                0: exec_nonload("rnd_bub", 0, r2[4], r2[5], r2[6], r2[7], r2[11:8], r, r2);
                1: exec_nonload("rnd_fl", 1, 1, r2[5], r2[6], r2[7], r2[11:8], r, r2);
                2, 3, 4: exec_nonload("rnd_alu", 1, 0, r2[5], r2[6], 0, r2[11:8], r, 32'd0);
                5, 6: exec_nonload("rnd_st", 1, 0, r2[5], r2[6], 1, r2[11:8], addr, $urandom());
                default: begin
                    int fa;
                    fa = (r2[14:12] == 3'd0) ? int'($urandom_range(1, RL)) : -1;
                    exec_load("rnd_ld", r2[5], r2[6], (r2[17:15] == 3'd0), r2[11:8], addr, fa);
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage between the execute/memory (M) control bundle and the memory/writeback pipeline register (the mwpipe).
- Issues loads and stores to a synchronous single-port data RAM (address, clock, data, wren, q).
- Holds the pipeline with a stall while load data is outstanding.
- Presents a registered bundle (pcload, regw, regmem, regScr, ALUrslt, read data, valid) that feeds the mwpipe `_M` inputs.

Parameters:
- DATA_W, 32, datapath / ALU result / RAM word width.
- ADDR_W, 10, RAM word-address width. Word address = ALUrslt_M[ADDR_W+1:2].
- REG_W, 4, destination register index width (regScr).
- READ_LATENCY, 2, edges from RAM address capture to valid q. Legal range 1..4.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  asynchronous active-high reset.
- valid_M  in  1  M-side bundle holds a real instruction.
- flush_M  in  1  kill current M instruction, synchronous.
- pcload_M  in  1  control passthrough.
- regw_M  in  1  register-write enable passthrough.
- regmem_M  in  1  instruction is a load; writeback selects memory data.
- memw_M  in  1  instruction is a store.
- regScr_M  in  REG_W  destination register index.
- ALUrslt_M  in  DATA_W  ALU result / byte address.
- wdata_M  in  DATA_W  store data.
- stall_o  out  1  hold upstream stages (combinational).
- mem_addr  out  ADDR_W  RAM address.
- mem_data  out  DATA_W  RAM write data.
- mem_wren  out  1  RAM write enable.
- mem_q  in  DATA_W  RAM read data.
- valid_o  out  1  registered bundle valid.
- pcload_o, regw_o, regmem_o  out  1 each  registered control.
- regScr_o  out  REG_W  registered destination index.
- ALUrslt_o  out  DATA_W  registered ALU result.
- rdata_o  out  DATA_W  registered load data; 0 for non-loads.

Behaviour:
- Reset (async, any state): state=IDLE, cnt=0. All *_o registers = 0. stall_o=0, mem_wren=0.
- Outputs change only on posedge, except stall_o and the mem_* signals, which are combinational from state and inputs.
- FSM states: IDLE, WAIT, DONE.
- IDLE, accept condition: valid_M & ~flush_M.
  - Non-load, non-store accepted: at the edge, *_o <= *_M, rdata_o <= 0, valid_o <= 1. Latency 1 cycle; stall_o = 0.
  - Store accepted (memw_M=1, regmem_M=0): mem_wren = 1 for this cycle only, mem_addr = word address, mem_data = wdata_M. Bundle registered as for a non-load. No stall.
  - Load accepted (regmem_M=1): stall_o = 1, mem_addr = word address, mem_wren = 0. Holding registers capture the address.
    - Next state is WAIT with cnt = READ_LATENCY-1, or DONE if READ_LATENCY = 1.
    - At this edge valid_o <= 0 (bubble).
  - regmem_M & memw_M together: treated as a load; the store is ignored.
  - Not accepted (valid_M=0 or flush_M=1): valid_o <= 0 and all control *_o <= 0. Data *_o <= 0. No RAM write.
- WAIT:
  - stall_o = 1; mem_addr held from holding register; mem_wren = 0; valid_o <= 0.
  - cnt decrements each cycle; when cnt reaches 1, next state is DONE.
- DONE:
  - stall_o = 0.
  - At the edge: rdata_o <= mem_q, other *_o <= *_M (upstream still holds the load), valid_o <= 1. Next state IDLE.
  - The load is not re-issued in DONE.
- Load timing: first stall cycle is C. stall_o is high for cycles C..C+READ_LATENCY-1. Result registers at the end of cycle C+READ_LATENCY, and upstream advances at the same edge.
- flush_M in WAIT or DONE: abort to IDLE; valid_o <= 0; no output update. stall_o drops in the flush cycle.
- Address wrap: addresses above the RAM depth wrap modulo 2^ADDR_W through truncation. Bits [1:0] are ignored unless MISALIGN_TRAP_EN is defined.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_o (1 bit, registered, reset 0).
  - A load or store accepted with ALUrslt_M[1:0] != 0:
    - no RAM access and no stall;
    - registered as a bubble with valid_o=1, regw_o=0, regmem_o=0;
    - misalign_o <= 1 for exactly one cycle.
- Undefined: port absent; low address bits are silently ignored.

Test Plan:
- Reset: assert rst mid-WAIT of a load with ALUrslt_M=0x40 -> immediately state IDLE, stall_o=0, all *_o=0. After release, no stray mem_wren.
- ALU op: valid_M=1, regw_M=1, regScr_M=4'b0011, ALUrslt_M=0x0000FFFF -> next edge valid_o=1, regScr_o=3, ALUrslt_o=0x0000FFFF, rdata_o=0, stall_o never high.
- Store: memw_M=1, ALUrslt_M=0x10, wdata_M=0xDEADBEEF -> mem_wren high for exactly one cycle, mem_addr=4, mem_data=0xDEADBEEF. A subsequent load of 0x10 returns rdata_o=0xDEADBEEF.
- Load, READ_LATENCY=2: load of 0x10 with regScr_M=4'b0100 -> stall_o high for exactly 2 cycles, then valid_o=1, regmem_o=1, regScr_o=4, rdata_o=0xDEADBEEF. A back-to-back ALU op follows with no extra bubble.
- Flush: load accepted, flush_M=1 in the WAIT cycle -> stall_o drops that cycle, valid_o stays 0, no result emitted.
- MISALIGN_TRAP_EN: store to 0x12 -> mem_wren stays 0, misalign_o=1 for one cycle, regw_o=0.
